// File: rtl/psx_ddr_avalon_responder.sv
// Avalon-MM burst responder standing in for the DDR controller behind the GPU bridge.
// Define PSX_DDR_RESP_STALL_EN to inject LFSR-driven wait-request and read-beat stalls.
module psx_ddr_avalon_responder #(
  parameter int DEPTH_LOG2 = 17,
  parameter int READ_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  i_nrst,
  input  logic [DEPTH_LOG2-1:0] i_targetAddr,
  input  logic [2:0]            i_burstLength,
  output logic                  o_busyMem,
  input  logic                  i_writeEnableMem,
  input  logic                  i_readEnableMem,
  input  logic [63:0]           i_dataMem,
  input  logic [7:0]            i_byteEnableMem,
  output logic                  o_dataValidMem,
  output logic [63:0]           o_dataMem,
  output logic                  o_protErr
);

  localparam int DATA_W = 64;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [2:0] LAT_INIT = (READ_LAT > 1) ? 3'(READ_LAT - 2) : 3'd0;

  typedef enum logic [1:0] {IDLE, WBURST, RLAT, RDATA} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            lat_q, lat_d;
  logic                  prot_q, prot_d;
  logic                  vld_q, vld_d;
  logic [DATA_W-1:0]     rdata_q;

  logic                  rd_go;
  logic [DEPTH_LOG2-1:0] rd_base;
  logic [2:0]            rd_left;
  logic                  beat_fire;
  logic                  mem_we;
  logic                  mem_wr;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic                  stall_acc;
  logic                  stall_beat;

  logic [DATA_W-1:0]     mem [DEPTH];

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    if (len == 3'd0) return 3'd1;
    if (len > 3'd4)  return 3'd4;
    return len;
  endfunction

`ifdef PSX_DDR_RESP_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) lfsr_q <= 16'hACE1;
    else         lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  assign stall_acc  = lfsr_q[0];
  assign stall_beat = &lfsr_q[1:0];
`else
  assign stall_acc  = 1'b0;
  assign stall_beat = 1'b0;
`endif

  assign o_busyMem      = (state_q == RLAT) || (state_q == RDATA) || stall_acc;
  assign o_dataValidMem = vld_q;
  assign o_dataMem      = rdata_q;
  assign o_protErr      = prot_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    prot_d    = prot_q;
    vld_d     = 1'b0;
    beat_fire = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    rd_go     = 1'b0;
    rd_base   = addr_q;
    rd_left   = cnt_q;

    case (state_q)
      IDLE: begin
        if (!o_busyMem) begin
          if (i_writeEnableMem) begin
            mem_we    = 1'b1;
            mem_waddr = i_targetAddr;
            addr_d    = i_targetAddr + ADDR_ONE;
            cnt_d     = clamp_len(i_burstLength) - 3'd1;
            if (cnt_d != 3'd0) state_d = WBURST;
            if (i_readEnableMem) prot_d = 1'b1;
          end else if (i_readEnableMem) begin
            if (READ_LAT == 1) begin
              rd_go   = 1'b1;
              rd_base = i_targetAddr;
              rd_left = clamp_len(i_burstLength);
            end else begin
              addr_d  = i_targetAddr;
              cnt_d   = clamp_len(i_burstLength);
              lat_d   = LAT_INIT;
              state_d = RLAT;
            end
          end
        end
      end
      WBURST: begin
        if (!o_busyMem) begin
          if (i_writeEnableMem) begin
            mem_we = 1'b1;
            addr_d = addr_q + ADDR_ONE;
            cnt_d  = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = IDLE;
          end
          if (i_readEnableMem) prot_d = 1'b1;
        end
      end
      RLAT: begin
        if (lat_q == 3'd0) rd_go = 1'b1;
        else               lat_d = lat_q - 3'd1;
      end
      RDATA: begin
        rd_go = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Beat issue: the beat loaded at this edge is presented during the next cycle.
    if (rd_go) begin
      state_d = RDATA;
      if (rd_left == 3'd0) begin
        state_d = IDLE;
      end else if (!stall_beat) begin
        beat_fire = 1'b1;
        vld_d     = 1'b1;
        addr_d    = rd_base + ADDR_ONE;
        cnt_d     = rd_left - 3'd1;
      end else begin
        addr_d = rd_base;
        cnt_d  = rd_left;
      end
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      prot_q  <= 1'b0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      prot_q  <= prot_d;
      vld_q   <= vld_d;
      if (beat_fire) rdata_q <= mem[rd_base];
    end
  end

  // Array contents survive reset; writes are simply blocked while reset is held.
  assign mem_wr = mem_we & i_nrst;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_byteEnableMem[b]) mem[mem_waddr][b*8 +: 8] <= i_dataMem[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_psx_ddr_avalon_responder.sv
// Scoreboard bench for psx_ddr_avalon_responder: model array plus queue of expected read beats.
module tb_psx_ddr_avalon_responder;

  localparam int AW = 17;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          i_nrst = 1'b0;
  logic [AW-1:0] i_targetAddr = '0;
  logic [2:0]    i_burstLength = '0;
  logic          o_busyMem;
  logic          i_writeEnableMem = 1'b0;
  logic          i_readEnableMem = 1'b0;
  logic [63:0]   i_dataMem = '0;
  logic [7:0]    i_byteEnableMem = '0;
  logic          o_dataValidMem;
  logic [63:0]   o_dataMem;
  logic          o_protErr;

  psx_ddr_avalon_responder #(.DEPTH_LOG2(AW), .READ_LAT(RL)) dut (
    .clk              (clk),
    .i_nrst           (i_nrst),
    .i_targetAddr     (i_targetAddr),
    .i_burstLength    (i_burstLength),
    .o_busyMem        (o_busyMem),
    .i_writeEnableMem (i_writeEnableMem),
    .i_readEnableMem  (i_readEnableMem),
    .i_dataMem        (i_dataMem),
    .i_byteEnableMem  (i_byteEnableMem),
    .o_dataValidMem   (o_dataValidMem),
    .o_dataMem        (o_dataMem),
    .o_protErr        (o_protErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [63:0] model [int];
  logic [63:0] wbuf [4];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int blen(input logic [2:0] l);
    if (l == 3'd0) return 1;
    if (l > 3'd4)  return 4;
    return int'(l);
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
    logic [63:0] w;
    w = model.exists(int'(a)) ? model[int'(a)] : 64'h0;
    for (int b = 0; b < 8; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
    model[int'(a)] = w;
  endtask

  // Called at a negedge; returns at a negedge where the responder is ready.
  task automatic wait_ready();
    int g = 0;
    while (o_busyMem !== 1'b0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) check_eq("ready_timeout", 64'd1, 64'd0);
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input logic [2:0] len, input logic [7:0] be);
    int n = blen(len);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      wait_ready();
      i_writeEnableMem = 1'b1;
      i_targetAddr     = a;
      i_burstLength    = len;
      i_dataMem        = wbuf[k];
      i_byteEnableMem  = be;
      model_write(a + AW'(k), wbuf[k], be);
    end
    @(negedge clk);
    i_writeEnableMem = 1'b0;
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input logic [2:0] len);
    int n = blen(len);
    int c0;
    int g;
    logic [AW-1:0] ra;
    @(negedge clk);
    wait_ready();
    i_readEnableMem = 1'b1;
    i_targetAddr    = a;
    i_burstLength   = len;
    c0 = cyc;
    for (int k = 0; k < n; k++) begin
      ra = a + AW'(k);
      sb.push_back('{model[int'(ra)], c0 + RL + k});
    end
    @(negedge clk);
    i_readEnableMem = 1'b0;
`ifndef PSX_DDR_RESP_STALL_EN
    check_eq("busy_after_accept", 64'(o_busyMem), 64'd1);
    g = 0;
    while (cyc < c0 + RL + n && g < 50) begin
      @(negedge clk);
      g++;
    end
    check_eq("busy_release", 64'(o_busyMem), 64'd0);
    check_eq("beats_done", 64'(sb.size()), 64'd0);
`else
    g = 0;
    while ((sb.size() != 0 || o_busyMem !== 1'b0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check_eq("burst_done", 64'(sb.size()), 64'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (i_nrst && o_dataValidMem) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("rdata", o_dataMem, mon_e.data);
`ifndef PSX_DDR_RESP_STALL_EN
        check_eq("beat_cycle", 64'(cyc), 64'(mon_e.cyc));
`endif
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int g;
    int nrand;
    logic [AW-1:0] ra;
    logic [2:0]    rl;

    repeat (3) @(negedge clk);
    check_eq("rst_busy",  64'(o_busyMem), 64'd0);
    check_eq("rst_valid", 64'(o_dataValidMem), 64'd0);
    check_eq("rst_data",  o_dataMem, 64'd0);
    check_eq("rst_prot",  64'(o_protErr), 64'd0);
    i_nrst = 1'b1;

    // Four-beat write then readback with exact beat timing.
    wbuf[0] = {16{4'h1}};
    wbuf[1] = {16{4'h2}};
    wbuf[2] = {16{4'h3}};
    wbuf[3] = {16{4'h4}};
    wr_burst(17'h00010, 3'd4, 8'hFF);
    rd_burst(17'h00010, 3'd4);
    check_eq("hold_last", o_dataMem, 64'h4444_4444_4444_4444);

    // Byte-enable merge.
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wr_burst(17'h00005, 3'd1, 8'hFF);
    wbuf[0] = 64'h0;
    wr_burst(17'h00005, 3'd1, 8'h0F);
    rd_burst(17'h00005, 3'd1);
    check_eq("be_merge", o_dataMem, 64'hFFFF_FFFF_0000_0000);

    // Address wrap at the top of the array.
    for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
    wr_burst(17'h1FFFE, 3'd4, 8'hFF);
    rd_burst(17'h1FFFE, 3'd4);
    rd_burst(17'h00000, 3'd1);
    check_eq("wrap_word0", o_dataMem, wbuf[2]);
    rd_burst(17'h00001, 3'd1);
    check_eq("wrap_word1", o_dataMem, wbuf[3]);
    check_eq("prot_still_clear", 64'(o_protErr), 64'd0);

    // Simultaneous read and write in IDLE: write wins, error flagged, no beats.
    @(negedge clk);
    wait_ready();
    i_writeEnableMem = 1'b1;
    i_readEnableMem  = 1'b1;
    i_targetAddr     = 17'h00020;
    i_burstLength    = 3'd1;
    i_dataMem        = 64'h0123_4567_89AB_CDEF;
    i_byteEnableMem  = 8'hFF;
    model_write(17'h00020, 64'h0123_4567_89AB_CDEF, 8'hFF);
    @(negedge clk);
    i_writeEnableMem = 1'b0;
    i_readEnableMem  = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("prot_set", 64'(o_protErr), 64'd1);
    rd_burst(17'h00020, 3'd1);
    check_eq("prot_sticky", 64'(o_protErr), 64'd1);

    // Reset pulse during beat 2 of a four-beat read.
    for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
    wr_burst(17'h00030, 3'd4, 8'hFF);
    @(negedge clk);
    wait_ready();
    i_readEnableMem = 1'b1;
    i_targetAddr    = 17'h00030;
    i_burstLength   = 3'd4;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      ra = 17'h00030 + AW'(k);
      sb.push_back('{model[int'(ra)], c0 + RL + k});
    end
    @(negedge clk);
    i_readEnableMem = 1'b0;
    g = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
    end while (cyc < c0 + RL + 2 && g < 50);
`ifndef PSX_DDR_RESP_STALL_EN
    check_eq("beat2_valid", 64'(o_dataValidMem), 64'd1);
    check_eq("beat2_data", o_dataMem, wbuf[2]);
`endif
    #1;
    i_nrst = 1'b0;
    sb.delete();
    #1;
    check_eq("async_rst_valid", 64'(o_dataValidMem), 64'd0);
    check_eq("async_rst_busy",  64'(o_busyMem), 64'd0);
    check_eq("async_rst_data",  o_dataMem, 64'd0);
    check_eq("async_rst_prot",  64'(o_protErr), 64'd0);
    @(negedge clk);
    i_nrst = 1'b1;
    rd_burst(17'h00033, 3'd1);
    check_eq("post_rst_read", o_dataMem, wbuf[3]);

    // Random bursts over a prefilled window, including out-of-range lengths.
    for (int base = 0; base < 72; base += 4) begin
      for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
      wr_burst(AW'(base), 3'd4, 8'hFF);
    end
`ifdef PSX_DDR_RESP_STALL_EN
    nrand = 1000;
`else
    nrand = 40;
`endif
    for (int i = 0; i < nrand; i++) begin
      ra = AW'($urandom_range(0, 63));
      rl = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
        wr_burst(ra, rl, 8'($urandom_range(0, 255)));
      end else begin
        rd_burst(ra, rl);
      end
    end

    repeat (8) @(negedge clk);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    check_eq("final_valid", 64'(o_dataValidMem), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
